// File: rtl/march_bist_pkg.sv
// Shared encodings for the March BIST engine: modes, ops, sweep direction and
// per-algorithm element counts.
package march_bist_pkg;

  localparam int MAX_ELEMS = 6;
  localparam int MAX_OPS   = 4;
  localparam int ELEM_W    = $clog2(MAX_ELEMS);
  localparam int OPIDX_W   = $clog2(MAX_OPS);

  typedef enum logic [1:0] {
    MODE_MATS     = 2'd0,
    MODE_MARCH_C  = 2'd1,
    MODE_MARCH_LR = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    OP_W0 = 2'd0,
    OP_W1 = 2'd1,
    OP_R0 = 2'd2,
    OP_R1 = 2'd3
  } op_e;

  // Ascending-or-don't-care elements sweep up
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [ELEM_W-1:0] elem_count(input logic [1:0] mode);
    case (mode)
      MODE_MATS:     elem_count = 3'd3;
      MODE_MARCH_C:  elem_count = 3'd6;
      MODE_MARCH_LR: elem_count = 3'd6;
      default:       elem_count = 3'd1;
    endcase
  endfunction

  function automatic logic op_is_write(input op_e op);
    op_is_write = (op == OP_W0) || (op == OP_W1);
  endfunction

endpackage

// File: rtl/march_algo_rom.sv
// Combinational algorithm table: (mode, element, op index) -> op, sweep
// direction and end-of-element / end-of-algorithm flags.
module march_algo_rom
  import march_bist_pkg::*;
(
  input  logic [1:0]         mode,
  input  logic [ELEM_W-1:0]  elem,
  input  logic [OPIDX_W-1:0] op_idx,
  output op_e                op,
  output dir_e               dir,
  output logic               last_op,
  output logic               last_elem
);

  op_e                op0_s, op1_s, op2_s, op3_s;
  logic [OPIDX_W-1:0] last_idx_s;

  // Element table; unlisted elements fall back to a single w0
  always_comb begin
    op0_s      = OP_W0;
    op1_s      = OP_W0;
    op2_s      = OP_W0;
    op3_s      = OP_W0;
    last_idx_s = 2'd0;
    dir        = DIR_UP;
    case (mode)
      MODE_MATS: begin
        case (elem)
          3'd1: begin op0_s = OP_R0; op1_s = OP_W1; last_idx_s = 2'd1; end
          3'd2: begin dir = DIR_DOWN; op0_s = OP_R1; op1_s = OP_W0; last_idx_s = 2'd1; end
          default: begin op0_s = OP_W0; end
        endcase
      end
      MODE_MARCH_C: begin
        case (elem)
          3'd1: begin op0_s = OP_R0; op1_s = OP_W1; last_idx_s = 2'd1; end
          3'd2: begin op0_s = OP_R1; op1_s = OP_W0; last_idx_s = 2'd1; end
          3'd3: begin dir = DIR_DOWN; op0_s = OP_R0; op1_s = OP_W1; last_idx_s = 2'd1; end
          3'd4: begin dir = DIR_DOWN; op0_s = OP_R1; op1_s = OP_W0; last_idx_s = 2'd1; end
          3'd5: begin op0_s = OP_R0; end
          default: begin op0_s = OP_W0; end
        endcase
      end
      MODE_MARCH_LR: begin
        case (elem)
          3'd1: begin dir = DIR_DOWN; op0_s = OP_R0; op1_s = OP_W1; last_idx_s = 2'd1; end
          3'd2: begin
            op0_s = OP_R1; op1_s = OP_W0; op2_s = OP_R0; op3_s = OP_W1; last_idx_s = 2'd3;
          end
          3'd3: begin op0_s = OP_R1; op1_s = OP_W0; last_idx_s = 2'd1; end
          3'd4: begin
            op0_s = OP_R0; op1_s = OP_W1; op2_s = OP_R1; op3_s = OP_W0; last_idx_s = 2'd3;
          end
          3'd5: begin op0_s = OP_R0; end
          default: begin op0_s = OP_W0; end
        endcase
      end
      default: begin op0_s = OP_W0; end
    endcase
  end

  // Select the op slot and derive the boundary flags
  always_comb begin
    case (op_idx)
      2'd0:    op = op0_s;
      2'd1:    op = op1_s;
      2'd2:    op = op2_s;
      2'd3:    op = op3_s;
      default: op = op0_s;
    endcase
    last_op   = (op_idx == last_idx_s);
    last_elem = (elem == (elem_count(mode) - 3'd1));
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March BIST controller (MATS+, March C-, March LR) for one single-port SRAM.
// Optional failure diagnostics are compiled in with `define MBIST_DIAG_EN.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 256,
  parameter  int RD_LAT = 1,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_syn,
  output logic [7:0]        fail_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_e;

  state_e             state_r;
  logic [1:0]         mode_r;
  logic [ELEM_W-1:0]  elem_r;
  logic [OPIDX_W-1:0] op_idx_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [2:0]         lat_r;
  op_e                cur_op_r;
  dir_e               cur_dir_r;
  logic               cur_last_op_r, cur_last_elem_r;
  logic               we_r, re_r, busy_r, done_r, fail_r;
  logic [DATA_W-1:0]  wdata_r;

  logic [1:0]         rom_mode_s;
  logic [ELEM_W-1:0]  nxt_elem_s;
  logic [OPIDX_W-1:0] nxt_op_idx_s;
  logic [ADDR_W-1:0]  nxt_addr_s, sweep_end_s;
  logic               new_elem_s, step_addr_s, seq_end_s;
  op_e                rom_op_s;
  dir_e               rom_dir_s;
  logic               rom_last_op_s, rom_last_elem_s;
  logic               accept_s, op_done_s, load_s, miss_s;
  logic [DATA_W-1:0]  exp_s, syn_s;

  // The ROM is always addressed with the op that will be issued next
  march_algo_rom u_rom (
    .mode      (rom_mode_s),
    .elem      (nxt_elem_s),
    .op_idx    (nxt_op_idx_s),
    .op        (rom_op_s),
    .dir       (rom_dir_s),
    .last_op   (rom_last_op_s),
    .last_elem (rom_last_elem_s)
  );

  assign rom_mode_s  = (state_r == ST_IDLE) ? mode : mode_r;
  assign accept_s    = (state_r == ST_IDLE) && start && (mode != MODE_RSVD);
  assign op_done_s   = (state_r == ST_RUN) && (op_is_write(cur_op_r) || (lat_r == 3'(RD_LAT)));
  assign load_s      = accept_s || (op_done_s && !seq_end_s);
  assign sweep_end_s = (cur_dir_r == DIR_DOWN) ? {ADDR_W{1'b0}} : LAST_ADDR;
  assign exp_s       = (cur_op_r == OP_R1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  assign syn_s       = mem_rdata ^ exp_s;
  assign miss_s      = (state_r == ST_RUN) && !op_is_write(cur_op_r) &&
                       (lat_r == 3'(RD_LAT)) && (syn_s != {DATA_W{1'b0}});

  // Next op position: next op on this address, next address, or next element
  always_comb begin
    nxt_elem_s   = elem_r;
    nxt_op_idx_s = op_idx_r;
    new_elem_s   = 1'b0;
    step_addr_s  = 1'b0;
    seq_end_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      nxt_elem_s   = {ELEM_W{1'b0}};
      nxt_op_idx_s = {OPIDX_W{1'b0}};
      new_elem_s   = 1'b1;
    end else if (!cur_last_op_r) begin
      nxt_op_idx_s = op_idx_r + 2'd1;
    end else if (addr_r != sweep_end_s) begin
      nxt_op_idx_s = {OPIDX_W{1'b0}};
      step_addr_s  = 1'b1;
    end else if (!cur_last_elem_r) begin
      nxt_elem_s   = elem_r + 3'd1;
      nxt_op_idx_s = {OPIDX_W{1'b0}};
      new_elem_s   = 1'b1;
    end else begin
      seq_end_s    = 1'b1;
    end
  end

  // Address for the next op; a new element reloads from its own direction
  always_comb begin
    if (new_elem_s) begin
      nxt_addr_s = (rom_dir_s == DIR_DOWN) ? LAST_ADDR : {ADDR_W{1'b0}};
    end else if (step_addr_s) begin
      nxt_addr_s = (cur_dir_r == DIR_DOWN) ? (addr_r - ADDR_W'(1)) : (addr_r + ADDR_W'(1));
    end else begin
      nxt_addr_s = addr_r;
    end
  end

`ifdef MBIST_DIAG_EN
  logic [ADDR_W-1:0] fail_addr_r;
  logic [2:0]        fail_elem_r;
  logic [DATA_W-1:0] fail_syn_r;
  logic [7:0]        fail_cnt_r;

  // First-mismatch capture and saturating mismatch count
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      fail_addr_r <= {ADDR_W{1'b0}};
      fail_elem_r <= 3'd0;
      fail_syn_r  <= {DATA_W{1'b0}};
      fail_cnt_r  <= 8'd0;
    end else if (miss_s) begin
      if (!fail_r) begin
        fail_addr_r <= addr_r;
        fail_elem_r <= elem_r;
        fail_syn_r  <= syn_s;
      end
      if (fail_cnt_r != 8'hFF) begin
        fail_cnt_r <= fail_cnt_r + 8'd1;
      end
    end
  end

  assign fail_addr = fail_addr_r;
  assign fail_elem = fail_elem_r;
  assign fail_syn  = fail_syn_r;
  assign fail_cnt  = fail_cnt_r;
`endif

  // FSM, op sequencing, memory strobes and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      mode_r          <= 2'd0;
      elem_r          <= {ELEM_W{1'b0}};
      op_idx_r        <= {OPIDX_W{1'b0}};
      addr_r          <= {ADDR_W{1'b0}};
      lat_r           <= 3'd0;
      cur_op_r        <= OP_W0;
      cur_dir_r       <= DIR_UP;
      cur_last_op_r   <= 1'b0;
      cur_last_elem_r <= 1'b0;
      we_r            <= 1'b0;
      re_r            <= 1'b0;
      wdata_r         <= {DATA_W{1'b0}};
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      fail_r          <= 1'b0;
    end else begin
      we_r <= 1'b0;
      re_r <= 1'b0;
      if (load_s) begin
        elem_r          <= nxt_elem_s;
        op_idx_r        <= nxt_op_idx_s;
        addr_r          <= nxt_addr_s;
        lat_r           <= 3'd0;
        cur_op_r        <= rom_op_s;
        cur_dir_r       <= rom_dir_s;
        cur_last_op_r   <= rom_last_op_s;
        cur_last_elem_r <= rom_last_elem_s;
        we_r            <= op_is_write(rom_op_s);
        re_r            <= !op_is_write(rom_op_s);
        wdata_r         <= (rom_op_s == OP_W1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        lat_r <= lat_r + 3'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_RUN;
            mode_r  <= mode;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (op_done_s && seq_end_s) begin
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (miss_s) begin
        fail_r <= 1'b1;
      end
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = we_r;
  assign mem_re    = re_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fail      = fail_r;

endmodule
